// File: rtl/mux_nx1_arb.sv
// Registered N:1 selector with per-channel valid/ready, direct or round-robin
// selection, and a single output register that streams at full throughput.
module mux_nx1_arb #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_idx_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  last_reg;

  logic             load;
  logic             xfer;
  logic             direct_hit;
  logic             rr_hi_found, rr_lo_found;
  logic [SELW-1:0]  rr_hi_idx, rr_lo_idx;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_data;

  assign load = !out_valid_reg || out_ready;

  // A select value with no matching channel (sel >= N) never grants.
  always_comb begin
    direct_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) direct_hit = in_valid[i];
    end
  end

  // Round-robin: lowest valid channel above last wins; otherwise wrap to the
  // lowest valid channel at or below last.
  always_comb begin
    rr_hi_found = 1'b0;
    rr_lo_found = 1'b0;
    rr_hi_idx   = '0;
    rr_lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (SELW'(i) > last_reg) begin
          rr_hi_found = 1'b1;
          rr_hi_idx   = SELW'(i);
        end else begin
          rr_lo_found = 1'b1;
          rr_lo_idx   = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant_any = rr_hi_found || rr_lo_found;
      grant_idx = rr_hi_found ? rr_hi_idx : rr_lo_idx;
    end else begin
      grant_any = direct_hit;
      grant_idx = sel;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && load && grant_any && (grant_idx == SELW'(gi));
    end
  endgenerate

  assign xfer = |in_ready;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_idx_reg   <= '0;
      last_reg      <= SELW'(N - 1);
    end else if (load) begin
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= sel_data;
        out_idx_reg   <= grant_idx;
        if (mode) last_reg <= grant_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_idx   = out_idx_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Bench for mux_nx1_arb: directed scenarios plus random traffic on a 4-channel
// instance checked against a rule-level model, and directed checks on N=3.
module tb_mux_nx1_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic         rst_n, mode, out_ready, out_valid;
  logic [1:0]   sel, out_idx;
  logic [127:0] in_data;
  logic [3:0]   in_valid, in_ready;
  logic [31:0]  out_data;

  mux_nx1_arb #(.WIDTH(32), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // 3-channel instance
  logic         rst3_n, mode3, out_ready3, out_valid3;
  logic [1:0]   sel3, out_idx3;
  logic [95:0]  in_data3;
  logic [2:0]   in_valid3, in_ready3;
  logic [31:0]  out_data3;

  mux_nx1_arb #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_idx(out_idx3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: output register contents and round-robin pointer as plain ints.
  bit          m_valid;
  logic [31:0] m_data;
  int          m_idx;
  int          m_last;

  function automatic bit ref_grant(input int n, input bit m, input int s,
                                   input logic [3:0] v, input int last, output int g);
    int c;
    g = 0;
    if (!m) begin
      if (s < n && v[s]) begin
        g = s;
        return 1'b1;
      end
      return 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      c = (last + k) % n;
      if (v[c]) begin
        g = c;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Inputs are already applied; check in_ready, take one edge, check outputs.
  task automatic step4();
    int g;
    bit hit;
    logic [3:0] er;
    #1;
    er  = 4'b0000;
    hit = ref_grant(4, mode, int'(sel), in_valid, m_last, g);
    if (rst_n && hit && (!m_valid || out_ready)) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_idx = 0; m_last = 3;
    end else if (!m_valid || out_ready) begin
      if (hit) begin
        m_valid = 1'b1;
        m_data  = in_data[g*32 +: 32];
        m_idx   = g;
        if (mode) m_last = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_idx", 32'(out_idx), 32'(m_idx));
    if (out_valid) $display("word idx=%0d data=%h", out_idx, out_data);
  endtask

  task automatic rand_data();
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_idx = 0; m_last = 3;
    rst3_n = 1'b0; mode3 = 1'b0; sel3 = 2'd0; in_data3 = '0;
    in_valid3 = 3'b000; out_ready3 = 1'b1;

    // Reset with every channel offering data
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    rand_data();
    step4();
    step4();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    // Round-robin over all-valid inputs
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step4();
      chk("rr_seq_idx", 32'(out_idx), 32'(i % 4));
      chk("rr_seq_valid", 32'(out_valid), 32'd1);
    end

    // Direct select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
    rand_data(); in_data[64 +: 32] = 32'hDEADBEEF;
    step4();
    chk("dir_data", out_data, 32'hDEADBEEF);
    chk("dir_idx", 32'(out_idx), 32'd2);
    in_valid = 4'b1011;
    step4();
    chk("dir_nogrant_valid", 32'(out_valid), 32'd0);

    // Backpressure after the first word
    rst_n = 1'b0; step4(); rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1111; rand_data();
    step4();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step4();
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_idx", 32'(out_idx), 32'd0);
    end
    out_ready = 1'b1;
    step4();
    chk("bp_resume_idx", 32'(out_idx), 32'd1);

    // Wrap-around and sparse valids
    step4(); step4();
    chk("wrap_last3", 32'(out_idx), 32'd3);
    in_valid = 4'b1010; rand_data(); step4();
    chk("sparse_1010", 32'(out_idx), 32'd1);
    in_valid = 4'b0001; rand_data(); step4();
    chk("sparse_0001", 32'(out_idx), 32'd0);
    in_valid = 4'b1001; rand_data(); step4();
    chk("sparse_1001", 32'(out_idx), 32'd3);

    // Random traffic, including mode flips, stalls and occasional resets
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      step4();
    end

    // N=3: out-of-range select, then reset while a word is stalled
    rst_n = 1'b0;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    #1;
    chk("n3_sel3_ready", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    chk("n3_sel3_valid", 32'(out_valid3), 32'd0);
    sel3 = 2'd1; in_data3 = {32'h0, 32'h12345678, 32'h0}; out_ready3 = 1'b0;
    #1;
    chk("n3_dir_ready", 32'(in_ready3), 32'b010);
    @(posedge clk); #1;
    chk("n3_dir_valid", 32'(out_valid3), 32'd1);
    chk("n3_dir_data", out_data3, 32'h12345678);
    chk("n3_dir_idx", 32'(out_idx3), 32'd1);
    chk("n3_stall_ready", 32'(in_ready3), 32'd0);
    rst3_n = 1'b0;
    @(posedge clk); #1;
    chk("n3_rst_valid", 32'(out_valid3), 32'd0);
    chk("n3_rst_data", out_data3, 32'd0);
    rst3_n = 1'b1; out_ready3 = 1'b1; in_valid3 = 3'b000;
    @(posedge clk); #1;
    chk("n3_no_redeliver", 32'(out_valid3), 32'd0);
    mode3 = 1'b1; in_valid3 = 3'b110;
    #1;
    chk("n3_rr_first", 32'(in_ready3), 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
